// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg
//   Shared types and constants for the memory BIST engine:
//   - state_t   : engine FSM states
//   - FC_*      : fail_code values reported on the fail_code port
//   - MODE_*    : data pattern selectors for the mode port
//   - XOR_SEED  : constant folded into the address-hash patterns
package mem_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      WRITE,
      READ,
      DONE,
      FAIL
   } state_t;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_RSVD     = 3'd1;  // reserved, never produced
   localparam logic [2:0] FC_WR_TMO   = 3'd2;  // FILL/WRITE access timed out
   localparam logic [2:0] FC_RD_TMO   = 3'd3;  // READ access timed out
   localparam logic [2:0] FC_MISMATCH = 3'd4;  // read data compare failed
   localparam logic [2:0] FC_ABORT    = 3'd5;  // run aborted

   localparam logic [1:0] MODE_XOR     = 2'd0;  // address-hash byte on every lane
   localparam logic [1:0] MODE_ADDR    = 2'd1;  // address as data
   localparam logic [1:0] MODE_WALK1   = 2'd2;  // walking one by word index
   localparam logic [1:0] MODE_XOR_INV = 2'd3;  // inverse of MODE_XOR

   localparam logic [7:0] XOR_SEED = 8'hC3;

endpackage

// File: rtl/mem_bist_pattern.sv
// mem_bist_pattern
//   Combinational pattern / expected-data generator.
//   Ports:
//     mode      : pattern select (MODE_*)
//     addr      : byte address of the current word
//     idx       : word index of the current word
//     lane_mask : byte lanes written during the pattern phase
//     pattern   : write data for the pattern phase
//     expected  : read-back data; pattern byte on masked lanes, 0xFF on
//                 lanes left untouched since the all-ones fill
module mem_bist_pattern
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 21
)(
   input  logic [1:0]          mode,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [IDX_W-1:0]    idx,
   input  logic [DATA_W/8-1:0] lane_mask,
   output logic [DATA_W-1:0]   pattern,
   output logic [DATA_W-1:0]   expected
);

   localparam int STRB_W = DATA_W / 8;
   // Pad the address to at least 24 bits so the upper slice a[ADDR_W-1:16]
   // always exists; bits beyond the byte are dropped when folded in.
   localparam int AW_P = (ADDR_W < 24) ? 24 : ADDR_W;
   localparam int WIDE = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

   logic [AW_P-1:0]  a_p;
   logic [AW_P-17:0] a_hi;
   logic [7:0]       xor_byte;
   logic [WIDE-1:0]  a_wide;
   logic [DATA_W-1:0] walk1;

   assign a_p      = AW_P'(addr);
   assign a_hi     = a_p[AW_P-1:16];
   assign xor_byte = a_p[7:0] ^ a_p[15:8] ^ a_hi[7:0] ^ XOR_SEED;
   assign a_wide   = WIDE'(addr);
   assign walk1    = DATA_W'(1) << (32'(idx) % DATA_W);

   always_comb begin
      pattern = '0;
      case (mode)
         MODE_XOR:     pattern = {STRB_W{xor_byte}};
         MODE_ADDR:    pattern = a_wide[DATA_W-1:0];
         MODE_WALK1:   pattern = walk1;
         MODE_XOR_INV: pattern = ~{STRB_W{xor_byte}};
         default:      pattern = '0;
      endcase
   end

   for (genvar k = 0; k < STRB_W; k++) begin : g_lane
      assign expected[k*8 +: 8] = lane_mask[k] ? pattern[k*8 +: 8] : 8'hFF;
   end

endmodule

// File: rtl/mem_bist_engine.sv
// mem_bist_engine
//   Memory BIST engine: fills WORDS words with all-ones, writes a selectable
//   pattern on the latched byte lanes, then reads every word back and
//   compares. One request in flight; a dead cycle separates requests.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     start, abort        : run control
//     mode, lane_mask     : pattern select and pattern-phase byte lanes
//     busy, done, pass    : status
//     fail_code/addr/exp/act : failure report
//     mem_*               : valid/ready memory request port
//     wr_/rd_ fast/slow   : per-access latency histogram counters
//   Build option: define MEM_BIST_LATENCY_STATS_EN to implement the latency
//   counters; otherwise they are tied to zero.
module mem_bist_engine
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W    = 23,
   parameter int DATA_W    = 32,
   parameter int WORDS     = 2097152,
   parameter int TIMEOUT   = 100,
   parameter int LAT_SPLIT = 10,
   parameter int CNT_W     = 24
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [DATA_W/8-1:0] lane_mask,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [2:0]          fail_code,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_exp,
   output logic [DATA_W-1:0]   fail_act,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [CNT_W-1:0]    wr_fast,
   output logic [CNT_W-1:0]    wr_slow,
   output logic [CNT_W-1:0]    rd_fast,
   output logic [CNT_W-1:0]    rd_slow
);

   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int LAT_W  = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRB_W);

   if (TIMEOUT < 1 || LAT_SPLIT < 1 || (DATA_W % 8) != 0) begin : g_bad_params
      $error("mem_bist_engine: illegal parameter combination");
   end

   state_t            state;
   logic [1:0]        mode_q;
   logic [STRB_W-1:0] lane_q;
   logic [IDX_W-1:0]  idx_q;
   logic [LAT_W-1:0]  lat_q;     // valid-high cycles already elapsed
   logic [LAT_W-1:0]  lat_now;   // latency if ready arrives this cycle
   logic [DATA_W-1:0] pat_wdata;
   logic [DATA_W-1:0] pat_exp;

   logic in_run, ack, timeout, start_go, abort_go, mismatch, last_word;

   mem_bist_pattern #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_pattern (
      .mode      (mode_q),
      .addr      (mem_addr),
      .idx       (idx_q),
      .lane_mask (lane_q),
      .pattern   (pat_wdata),
      .expected  (pat_exp)
   );

   assign in_run    = (state == FILL) || (state == WRITE) || (state == READ);
   assign lat_now   = lat_q + 1'b1;
   // abort beats a coincident ready: the access is not completed
   assign ack       = in_run && mem_valid && mem_ready && !abort;
   assign timeout   = in_run && mem_valid && !mem_ready && !abort &&
                      (lat_now == LAT_W'(TIMEOUT));
   assign abort_go  = abort && (state != IDLE);
   assign start_go  = start && ((state == IDLE) ||
                      (((state == DONE) || (state == FAIL)) && !abort));
   assign mismatch  = (state == READ) && ack && (mem_rdata != pat_exp);
   assign last_word = (idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mode_q    <= '0;
         lane_q    <= '0;
         idx_q     <= '0;
         lat_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_code <= FC_NONE;
         fail_addr <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= '0;
         mem_wdata <= '0;
      end else if (start_go) begin
         mode_q    <= mode;
         lane_q    <= lane_mask;
         state     <= FILL;
         busy      <= 1'b1;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_code <= FC_NONE;
         fail_addr <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wstrb <= '0;
         mem_wdata <= '0;
         idx_q     <= '0;
         lat_q     <= '0;
      end else if (abort_go) begin
         state     <= FAIL;
         busy      <= 1'b0;
         done      <= 1'b1;
         pass      <= 1'b0;
         fail_code <= FC_ABORT;
         mem_valid <= 1'b0;
         if (in_run) fail_addr <= mem_addr;
      end else if (in_run) begin
         if (!mem_valid) begin
            // Request goes out one cycle after word/phase entry.
            mem_valid <= 1'b1;
            lat_q     <= '0;
            case (state)
               FILL: begin
                  mem_wstrb <= '1;
                  mem_wdata <= '1;
               end
               WRITE: begin
                  mem_wstrb <= lane_q;
                  mem_wdata <= pat_wdata;
               end
               default: begin
                  mem_wstrb <= '0;
                  mem_wdata <= '0;
               end
            endcase
         end else if (timeout) begin
            mem_valid <= 1'b0;
            state     <= FAIL;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail_code <= (state == READ) ? FC_RD_TMO : FC_WR_TMO;
            fail_addr <= mem_addr;
         end else if (ack) begin
            mem_valid <= 1'b0;
            if (mismatch) begin
               state     <= FAIL;
               busy      <= 1'b0;
               done      <= 1'b1;
               fail_code <= FC_MISMATCH;
               fail_addr <= mem_addr;
               fail_exp  <= pat_exp;
               fail_act  <= mem_rdata;
            end else if (last_word) begin
               mem_addr <= '0;
               idx_q    <= '0;
               case (state)
                  FILL:  state <= WRITE;
                  WRITE: state <= READ;
                  default: begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end
               endcase
            end else begin
               mem_addr <= mem_addr + ADDR_STEP;
               idx_q    <= idx_q + 1'b1;
            end
         end else begin
            lat_q <= lat_now;
         end
      end
   end

`ifdef MEM_BIST_LATENCY_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic fast_hit;
   assign fast_hit = 32'(lat_now) <= $unsigned(LAT_SPLIT);

   // FILL accesses are not counted; only the pattern write and read-back.
   always_ff @(posedge clk) begin
      if (reset || start_go) begin
         wr_fast <= '0;
         wr_slow <= '0;
         rd_fast <= '0;
         rd_slow <= '0;
      end else if (ack && (state == WRITE)) begin
         if (fast_hit) wr_fast <= sat_inc(wr_fast);
         else          wr_slow <= sat_inc(wr_slow);
      end else if (ack && (state == READ)) begin
         if (fast_hit) rd_fast <= sat_inc(rd_fast);
         else          rd_slow <= sat_inc(rd_slow);
      end
   end
`else
   assign wr_fast = '0;
   assign wr_slow = '0;
   assign rd_fast = '0;
   assign rd_slow = '0;
`endif

endmodule
